// File: rtl/exp_batch_sequencer_if.sv
// Handshake and data bundle between the batch sequencer, its operand ROM, the exp engine and the display.
// Latency: none. This is a wiring bundle only.
// Backpressure: none in the bundle itself. The engine stalls the sequencer through eng_done, and the user stalls it through step.
//
// Signals
//   start, step_mode, step       : user controls (level switches), toward the sequencer
//   rom_addr / rom_q             : ROM read port; rom_q follows rom_addr by the ROM latency
//   eng_x, eng_start             : operand and one-cycle start pulse toward the engine
//   eng_done, eng_intpart/frac   : completion and result from the engine
//   res_*, busy, done,
//   timeout_err                  : display-facing results and status from the sequencer
//
// Modports: master = sequencer side, slave = environment side (ROM, engine, user, display).
interface exp_batch_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              step_mode;
    logic              step;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_q;
    logic [15:0]       eng_x;
    logic              eng_start;
    logic              eng_done;
    logic [1:0]        eng_intpart;
    logic [15:0]       eng_fracpart;
    logic [1:0]        res_int;
    logic [15:0]       res_frac;
    logic [ADDR_W-1:0] res_addr;
    logic              res_valid;
    logic              busy;
    logic              done;
    logic              timeout_err;

    modport master (
        input  start, step_mode, step, rom_q, eng_done, eng_intpart, eng_fracpart,
        output rom_addr, eng_x, eng_start, res_int, res_frac, res_addr, res_valid,
               busy, done, timeout_err
    );

    modport slave (
        output start, step_mode, step, rom_q, eng_done, eng_intpart, eng_fracpart,
        input  rom_addr, eng_x, eng_start, res_int, res_frac, res_addr, res_valid,
               busy, done, timeout_err
    );
endinterface

// File: rtl/exp_batch_sequencer.sv
// Walks ROM operands 0..COUNT-1 through the exp engine and captures each result for display.
// Latency: first eng_start comes ROM_LAT+2 cycles after the start edge; each item then takes ROM_LAT+4+engine cycles.
// Backpressure: waits in WAIT for eng_done (watchdog bounded); in step mode, waits in HOLD after each result until a step edge.
//
// Ports
//   clk     : system clock
//   rst     : asynchronous active-low reset; every output returns to 0
//   bus_io  : exp_batch_sequencer_if.master (ROM port, engine port, user controls, results/status)
module exp_batch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int COUNT   = 256,
    parameter int ROM_LAT = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    exp_batch_sequencer_if.master        bus_io
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ROMWAIT = 4'd1;
    localparam logic [3:0] S_LATCH   = 4'd2;
    localparam logic [3:0] S_START   = 4'd3;
    localparam logic [3:0] S_WAIT    = 4'd4;
    localparam logic [3:0] S_STORE   = 4'd5;
    localparam logic [3:0] S_HOLD    = 4'd6;
    localparam logic [3:0] S_NEXT    = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COUNT - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(ROM_LAT - 1);
    // The eng_start cycle counts toward the watchdog budget. The abort therefore
    // lands exactly TIMEOUT cycles after eng_start. The watchdog reads 0 in the
    // first WAIT cycle, so the last WAIT cycle is the one where it reads TIMEOUT-2.
    // With TIMEOUT=1 this still leaves one WAIT cycle.
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT >= 2) ? (TIMEOUT - 2) : 0);

    logic [3:0]        state_q,    state_d;
    logic              start_q;
    logic              step_q;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]       eng_x_q,    eng_x_d;
    logic [LAT_W-1:0]  lat_q,      lat_d;
    logic [WD_W-1:0]   wd_q,       wd_d;
    logic [1:0]        res_int_q,  res_int_d;
    logic [15:0]       res_frac_q, res_frac_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic              to_err_q,   to_err_d;

    logic start_edge;
    logic step_edge;

    // The switches are registered once. A rising edge is the current level high while the previous level was low.
    assign start_edge = bus_io.start & ~start_q;
    assign step_edge  = bus_io.step  & ~step_q;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        eng_x_d    = eng_x_q;
        lat_d      = lat_q;
        wd_d       = wd_q;
        res_int_d  = res_int_q;
        res_frac_d = res_frac_q;
        res_addr_d = res_addr_q;
        to_err_d   = to_err_q;

        case (state_q)
            // DONE restarts exactly like IDLE. A new run clears any stale watchdog error.
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    rom_addr_d = '0;
                    to_err_d   = 1'b0;
                    lat_d      = '0;
                    state_d    = S_ROMWAIT;
                end
            end

            // Count ROM_LAT cycles from the address change, so rom_q is current when we reach LATCH.
            S_ROMWAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = S_LATCH;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            S_LATCH: begin
                eng_x_d = bus_io.rom_q;
                state_d = S_START;
            end

            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end

            // The result registers load on the same edge that enters STORE.
            // This way res_* are already valid during the res_valid pulse, not one cycle after it.
            // An aborted run never reaches this load, so earlier results survive a timeout.
            S_WAIT: begin
                if (bus_io.eng_done) begin
                    res_int_d  = bus_io.eng_intpart;
                    res_frac_d = bus_io.eng_fracpart;
                    res_addr_d = rom_addr_q;
                    state_d    = S_STORE;
                end else if (wd_q >= WD_LAST) begin
                    to_err_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            S_STORE: begin
                state_d = bus_io.step_mode ? S_HOLD : S_NEXT;
            end

            // step_mode is read as a level. Dropping it releases the pause, just as a step edge does.
            S_HOLD: begin
                if (step_edge || !bus_io.step_mode) begin
                    state_d = S_NEXT;
                end
            end

            // The address stops at the last operand. It never wraps.
            S_NEXT: begin
                if (rom_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    lat_d      = '0;
                    state_d    = S_ROMWAIT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            step_q     <= 1'b0;
            rom_addr_q <= '0;
            eng_x_q    <= '0;
            lat_q      <= '0;
            wd_q       <= '0;
            res_int_q  <= '0;
            res_frac_q <= '0;
            res_addr_q <= '0;
            to_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= bus_io.start;
            step_q     <= bus_io.step;
            rom_addr_q <= rom_addr_d;
            eng_x_q    <= eng_x_d;
            lat_q      <= lat_d;
            wd_q       <= wd_d;
            res_int_q  <= res_int_d;
            res_frac_q <= res_frac_d;
            res_addr_q <= res_addr_d;
            to_err_q   <= to_err_d;
        end
    end

    // The pulses and status flags decode straight from the state register.
    // Reset therefore clears them at once, and no eng_start can be left pending.
    assign bus_io.rom_addr    = rom_addr_q;
    assign bus_io.eng_x       = eng_x_q;
    assign bus_io.eng_start   = (state_q == S_START);
    assign bus_io.res_int     = res_int_q;
    assign bus_io.res_frac    = res_frac_q;
    assign bus_io.res_addr    = res_addr_q;
    assign bus_io.res_valid   = (state_q == S_STORE);
    assign bus_io.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus_io.done        = (state_q == S_DONE);
    assign bus_io.timeout_err = to_err_q;

endmodule

// File: tb/tb_exp_batch_sequencer.sv
// Self-checking bench for exp_batch_sequencer: table-driven runs, hand-written corner sequences, randomized runs.
// Latency: expected event cycles come from the per-item cycle budget, not from the design's state machine.
// Backpressure: an engine model returns done after a chosen latency (0 = never); step/step_mode are driven directly.
module tb_exp_batch_sequencer;

    localparam int ADDR_W  = 4;
    localparam int COUNT   = 4;
    localparam int ROM_LAT = 2;
    localparam int TIMEOUT = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    exp_batch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    exp_batch_sequencer #(
        .ADDR_W (ADDR_W),
        .COUNT  (COUNT),
        .ROM_LAT(ROM_LAT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 8;

    // Observation records for the current run.
    int                st_cyc[$];
    logic [15:0]       st_x[$];
    int                rv_cyc[$];
    logic [ADDR_W-1:0] rv_addr[$];
    logic [1:0]        rv_int[$];
    logic [15:0]       rv_frac[$];
    int                done_cyc = -1;
    logic              done_prev = 1'b0;
    int                max_addr = 0;

    // ROM and engine model state.
    logic [ADDR_W-1:0] ahist[0:7];
    int                eng_lats[$];
    logic              eng_pend = 1'b0;
    int                eng_due = -1;
    logic [15:0]       eng_xin = '0;
    logic              spurious = 1'b0;

    typedef struct {
        int lat;
        int done_off;
        int nvalid;
        int to;
    } vec_t;
    vec_t tbl[4];

    function automatic logic [15:0] rom_word(input logic [ADDR_W-1:0] a);
        return {a, 12'h000};
    endfunction

    function automatic logic [15:0] frac_of(input logic [15:0] x);
        return x ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        int lat;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.eng_start === 1'b1) begin
            st_cyc.push_back(cyc);
            st_x.push_back(bus.eng_x);
        end
        if (bus.res_valid === 1'b1) begin
            rv_cyc.push_back(cyc);
            rv_addr.push_back(bus.res_addr);
            rv_int.push_back(bus.res_int);
            rv_frac.push_back(bus.res_frac);
        end
        if (bus.done && !done_prev && done_cyc < 0) done_cyc = cyc;
        done_prev = bus.done;
        if (int'(bus.rom_addr) > max_addr) max_addr = int'(bus.rom_addr);
        // The ROM returns the word for the address that was presented ROM_LAT cycles ago.
        ahist[cyc % 8] = bus.rom_addr;
        bus.rom_q      = rom_word(ahist[(cyc - ROM_LAT) % 8]);
        // Engine model: the result fields carry junk except in the done cycle.
        bus.eng_done     = 1'b0;
        bus.eng_intpart  = 2'($urandom);
        bus.eng_fracpart = 16'($urandom);
        if (bus.eng_start === 1'b1) begin
            eng_xin  = bus.eng_x;
            eng_pend = 1'b1;
            lat      = (eng_lats.size() > 0) ? eng_lats.pop_front() : 3;
            eng_due  = (lat > 0) ? cyc + lat : -1;
        end else if (eng_pend) begin
            if (cyc == eng_due) begin
                bus.eng_done     = 1'b1;
                bus.eng_intpart  = eng_xin[13:12];
                bus.eng_fracpart = frac_of(eng_xin);
                eng_pend         = 1'b0;
            end
        end else if (spurious && $urandom_range(3) == 0) begin
            bus.eng_done = 1'b1;
        end
    endtask

    task automatic clear_rec();
        st_cyc.delete();  st_x.delete();
        rv_cyc.delete();  rv_addr.delete(); rv_int.delete(); rv_frac.delete();
        eng_lats.delete();
        done_cyc = -1;
        max_addr = 0;
    endtask

    task automatic pulse_start(output int e);
        e = cyc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cyc < 0 && k < 300) begin
            tick();
            k++;
        end
        chk({tag, "_reached_done"}, 32'(done_cyc >= 0), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int n);
        int k = 0;
        while (rv_cyc.size() < n && k < 200) begin
            tick();
            k++;
        end
        chk({tag, "_reached_valid"}, 32'(rv_cyc.size() >= n), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"},  {bus.eng_start, bus.res_valid, bus.busy, bus.done, bus.timeout_err}, 32'd0);
        chk({tag, "_addr"}, {bus.rom_addr, bus.res_addr}, 32'd0);
        chk({tag, "_engx"}, bus.eng_x, 32'd0);
        chk({tag, "_res"},  {bus.res_int, bus.res_frac}, 32'd0);
    endtask

    // Reference timeline derived from the cycle budget.
    // With start edge in cycle E, item 0 starts at E+ROM_LAT+2.
    // An engine latency d puts the capture d+1 cycles after eng_start.
    // The next eng_start follows ROM_LAT+3 cycles after the capture.
    // DONE follows 2 cycles after the last capture, or TIMEOUT cycles after an unanswered eng_start.
    task automatic check_run(input string tag, input int e, input int ml[$]);
        int s, r, exp_done, n_st, n_rv, to;
        s = e + ROM_LAT + 2;
        n_st = 0; n_rv = 0; to = 0; exp_done = 0;
        for (int i = 0; i < COUNT; i++) begin
            if (n_st < st_cyc.size()) begin
                chk($sformatf("%s_start%0d_cyc", tag, i), st_cyc[n_st] - e, s - e);
                chk($sformatf("%s_start%0d_x", tag, i), st_x[n_st], rom_word(ADDR_W'(i)));
            end
            n_st++;
            if (ml[i] == 0) begin
                to = 1;
                exp_done = s + TIMEOUT;
                break;
            end
            r = s + ml[i] + 1;
            if (n_rv < rv_cyc.size()) begin
                chk($sformatf("%s_valid%0d_cyc", tag, i), rv_cyc[n_rv] - e, r - e);
                chk($sformatf("%s_valid%0d_addr", tag, i), rv_addr[n_rv], i);
                chk($sformatf("%s_valid%0d_int", tag, i), rv_int[n_rv], 32'(i % 4));
                chk($sformatf("%s_valid%0d_frac", tag, i), rv_frac[n_rv], frac_of(rom_word(ADDR_W'(i))));
            end
            n_rv++;
            exp_done = r + 2;
            s = r + ROM_LAT + 3;
        end
        chk({tag, "_n_starts"}, st_cyc.size(), n_st);
        chk({tag, "_n_valids"}, rv_cyc.size(), n_rv);
        chk({tag, "_done_cyc"}, done_cyc - e, exp_done - e);
        chk({tag, "_timeout_err"}, bus.timeout_err, to);
        chk({tag, "_addr_bound"}, 32'(max_addr <= COUNT - 1), 32'd1);
    endtask

    initial begin
        int e, p, c;
        int ml[$];
        bus.start = 1'b0; bus.step = 1'b0; bus.step_mode = 1'b0;
        bus.eng_done = 1'b0; bus.eng_intpart = '0; bus.eng_fracpart = '0; bus.rom_q = '0;
        for (int i = 0; i < 8; i++) ahist[i] = '0;

        // Reset state.
        tick(); tick();
        chk_outputs_zero("reset");
        rst = 1'b1;
        tick(); tick();
        chk_outputs_zero("post_reset_idle");

        // Table: {engine latency, cycles start-edge->done, res_valid count, timeout_err}.
        // COUNT=4, ROM_LAT=2 gives done = 4*lat + 25. A never-answering engine aborts at 4 + TIMEOUT.
        tbl[0] = '{lat: 1, done_off: 29, nvalid: 4, to: 0};
        tbl[1] = '{lat: 5, done_off: 45, nvalid: 4, to: 0};
        tbl[2] = '{lat: 2, done_off: 33, nvalid: 4, to: 0};
        tbl[3] = '{lat: 0, done_off: 14, nvalid: 0, to: 1};
        for (int t = 0; t < 4; t++) begin
            clear_rec();
            ml.delete();
            for (int i = 0; i < COUNT; i++) begin
                eng_lats.push_back(tbl[t].lat);
                ml.push_back(tbl[t].lat);
            end
            pulse_start(e);
            wait_done($sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d_done_off", t), done_cyc - e, tbl[t].done_off);
            chk($sformatf("tbl%0d_nvalid", t), rv_cyc.size(), tbl[t].nvalid);
            chk($sformatf("tbl%0d_to_err", t), bus.timeout_err, tbl[t].to);
            chk($sformatf("tbl%0d_busy_in_done", t), {bus.busy, bus.done}, 32'b01);
            check_run($sformatf("tbl%0d", t), e, ml);
        end
        // The aborted run must not touch the results of the run before it.
        chk("timeout_res_hold", {bus.res_addr, bus.res_frac}, {4'd3, frac_of(16'h3000)});

        // Restart after the timeout clears timeout_err at once.
        clear_rec();
        ml = '{2, 2, 2, 2};
        eng_lats = ml;
        pulse_start(e);
        chk("restart_clears_to_err", {bus.timeout_err, bus.busy}, 32'b01);
        wait_done("after_to");
        check_run("after_to", e, ml);

        // Step mode: pause after each result. A held step advances only once. Dropping step_mode resumes.
        clear_rec();
        ml = '{3, 3, 3, 3};
        eng_lats = ml;
        bus.step_mode = 1'b1;
        pulse_start(e);
        wait_valid("step1", 1);
        repeat (10) tick();
        chk("hold_no_start", st_cyc.size(), 32'd1);
        chk("hold_busy", bus.busy, 32'd1);
        p = cyc;
        bus.step = 1'b1;
        wait_valid("step2", 2);
        if (st_cyc.size() >= 2) chk("step_advance_cyc", st_cyc[1] - p, ROM_LAT + 3);
        repeat (10) tick();
        chk("step_held_one_advance", st_cyc.size(), 32'd2);
        c = cyc;
        bus.step_mode = 1'b0;
        bus.step = 1'b0;
        wait_done("step_resume");
        if (st_cyc.size() >= 3) chk("resume_start_cyc", st_cyc[2] - c, ROM_LAT + 3);
        chk("step_nvalid", rv_cyc.size(), 32'd4);
        chk("step_last_addr", bus.res_addr, 32'd3);

        // Asynchronous reset in WAIT of item 1.
        clear_rec();
        eng_lats = '{2, 8, 2, 2};
        pulse_start(e);
        begin
            int k = 0;
            while (st_cyc.size() < 2 && k < 100) begin tick(); k++; end
            chk("mid_reset_reached_item1", st_cyc.size(), 32'd2);
        end
        tick();
        #3 rst = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        eng_pend = 1'b0;
        tick();
        rst = 1'b1;
        clear_rec();
        repeat (5) tick();
        chk("no_pending_start", st_cyc.size(), 32'd0);
        chk("post_reset_busy", {bus.busy, bus.done}, 32'd0);
        ml = '{1, 4, 2, 3};
        eng_lats = ml;
        pulse_start(e);
        wait_done("after_reset");
        check_run("after_reset", e, ml);

        // Restart from DONE, with a start edge while busy and spurious eng_done outside WAIT.
        // The results must keep their old values until the first new capture.
        clear_rec();
        ml = '{4, 1, 3, 2};
        eng_lats = ml;
        spurious = 1'b1;
        pulse_start(e);
        begin
            int k = 0;
            while (st_cyc.size() < 1 && k < 50) begin tick(); k++; end
        end
        chk("restart_res_hold", {bus.res_addr, bus.res_frac}, {4'd3, frac_of(16'h3000)});
        tick(); tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("restart");
        check_run("restart", e, ml);

        // Randomized runs against the timeline model.
        for (int run = 0; run < 4; run++) begin
            clear_rec();
            ml.delete();
            for (int i = 0; i < COUNT; i++) ml.push_back($urandom_range(6, 1));
            eng_lats = ml;
            pulse_start(e);
            repeat ($urandom_range(10, 2)) tick();
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            wait_done($sformatf("rnd%0d", run));
            check_run($sformatf("rnd%0d", run), e, ml);
            repeat ($urandom_range(4, 1)) tick();
        end
        spurious = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
